// File: rtl/aap_fetch_stage.sv
// AAP instruction fetch stage: walks the word-addressed PC, reads 16-bit words
// over req/ack, assembles 16/32-bit instructions and hands them to the decoder.
module aap_fetch_stage #(
   parameter int unsigned         PC_W     = 24,
   parameter logic [PC_W-1:0]     RESET_PC = '0
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [15:0]     fetchoutput,
   output logic [15:0]     fetchoutput_ext,
   output logic            fetch_is32,
   output logic [PC_W-1:0] fetch_pc
);

   typedef enum logic [1:0] {FETCH1, FETCH2, PRESENT} state_t;

   localparam logic [PC_W-1:0] ONE = 1;

   state_t          state, state_nx;
   logic [PC_W-1:0] pc, pc_nx, pc_inc;
   logic            req_nx, valid_nx, is32_nx;
   logic [PC_W-1:0] addr_nx, fpc_nx;
   logic [15:0]     out_nx, ext_nx;

   assign pc_inc = pc + ONE;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state           <= FETCH1;
         pc              <= RESET_PC;
         imem_req        <= 1'b0;
         imem_addr       <= '0;
         fetch_valid     <= 1'b0;
         fetchoutput     <= '0;
         fetchoutput_ext <= '0;
         fetch_is32      <= 1'b0;
         fetch_pc        <= '0;
      end else begin
         state           <= state_nx;
         pc              <= pc_nx;
         imem_req        <= req_nx;
         imem_addr       <= addr_nx;
         fetch_valid     <= valid_nx;
         fetchoutput     <= out_nx;
         fetchoutput_ext <= ext_nx;
         fetch_is32      <= is32_nx;
         fetch_pc        <= fpc_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      req_nx   = imem_req;
      addr_nx  = imem_addr;
      valid_nx = fetch_valid;
      out_nx   = fetchoutput;
      ext_nx   = fetchoutput_ext;
      is32_nx  = fetch_is32;
      fpc_nx   = fetch_pc;
      // Redirect wins over everything; any word acked this cycle is dropped.
      if (redirect_valid) begin
         pc_nx    = redirect_pc;
         state_nx = FETCH1;
         valid_nx = 1'b0;
         req_nx   = 1'b0;
      end else begin
         case (state)
            FETCH1: begin
               if (!imem_req) begin
                  req_nx  = 1'b1;
                  addr_nx = pc;
               end else if (imem_ack) begin
                  out_nx = imem_rdata;
                  fpc_nx = pc;
                  pc_nx  = pc_inc;
                  if (imem_rdata[15]) begin
                     // Keep the request up and move straight on to the second word.
                     state_nx = FETCH2;
                     addr_nx  = pc_inc;
                  end else begin
                     ext_nx   = '0;
                     is32_nx  = 1'b0;
                     req_nx   = 1'b0;
                     valid_nx = 1'b1;
                     state_nx = PRESENT;
                  end
               end
            end
            FETCH2: begin
               if (!imem_req) begin
                  req_nx  = 1'b1;
                  addr_nx = pc;
               end else if (imem_ack) begin
                  ext_nx   = imem_rdata;
                  is32_nx  = 1'b1;
                  pc_nx    = pc_inc;
                  req_nx   = 1'b0;
                  valid_nx = 1'b1;
                  state_nx = PRESENT;
               end
            end
            PRESENT: begin
               if (fetch_ready) begin
                  valid_nx = 1'b0;
                  state_nx = FETCH1;
                  req_nx   = 1'b1;
                  addr_nx  = pc;
               end
            end
            default: state_nx = FETCH1;
         endcase
      end
   end

endmodule
